// File: rtl/pipe_alu_pkg.sv
// Shared opcode encoding, default sizes and operand/flag decode for pipe_alu_core.
package pipe_alu_pkg;

  localparam int unsigned DATA_W_DEF = 9;
  localparam int unsigned NREG_DEF   = 8;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } opcode_e;

  // Returns {rx_read, ry_read}.
  function automatic logic [1:0] src_use(input opcode_e op);
    case (op)
      OP_MVI:        src_use = 2'b00;
      OP_MV, OP_NOT: src_use = 2'b01;
      default:       src_use = 2'b11;
    endcase
  endfunction

  // Returns {carry_update, zero_update}; only add/sub define carry.
  function automatic logic [1:0] flag_upd(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB:                 flag_upd = 2'b11;
      OP_AND, OP_OR, OP_XOR, OP_NOT:  flag_upd = 2'b01;
      default:                        flag_upd = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pipe_alu_unit.sv
// Combinational ALU: result, carry/borrow and zero from opcode and two operands.
module pipe_alu_unit
  import pipe_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~b;
      default: result = b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/pipe_alu_core.sv
// Three-stage register-file ALU pipeline. Define PIPE_ALU_FORWARD_EN for operand
// bypassing (never stalls); otherwise read-after-write hazards stall in_ready.
module pipe_alu_core
  import pipe_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  localparam int unsigned RA_W  = $clog2(NREG),
  localparam int unsigned IW    = 3 + 2 * RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_instr,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              carry,
  output logic              zero,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];

  opcode_e           op_in;
  logic [RA_W-1:0]   rx_in, ry_in;
  logic [1:0]        use_in;
  logic [DATA_W-1:0] imm, rx_val, ry_val, opa, opb;
  logic              accept;

  logic              s1_valid, s2_valid, s3_valid;
  opcode_e           s1_op;
  logic [RA_W-1:0]   s1_rd, s2_rd, s3_rd;
  logic [DATA_W-1:0] s1_a, s1_b, s2_res, s3_res;
  logic              s2_c, s2_z, s3_c, s3_z;
  logic [1:0]        s2_fl, s3_fl;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z;

  assign op_in    = opcode_e'(in_instr[IW-1 -: 3]);
  assign rx_in    = in_instr[2*RA_W-1 -: RA_W];
  assign ry_in    = in_instr[RA_W-1:0];
  assign use_in   = src_use(op_in);
  assign imm      = DATA_W'($signed(ry_in));
  assign accept   = in_valid && in_ready;
  assign dbg_data = regs[dbg_addr];

`ifdef PIPE_ALU_FORWARD_EN
  // Youngest producer wins; r0 never forwards since its writes are dropped.
  always_comb begin
    rx_val = regs[rx_in];
    if (s3_valid && s3_rd == rx_in) rx_val = s3_res;
    if (s2_valid && s2_rd == rx_in) rx_val = s2_res;
    if (s1_valid && s1_rd == rx_in) rx_val = alu_res;
    if (rx_in == '0) rx_val = '0;
    ry_val = regs[ry_in];
    if (s3_valid && s3_rd == ry_in) ry_val = s3_res;
    if (s2_valid && s2_rd == ry_in) ry_val = s2_res;
    if (s1_valid && s1_rd == ry_in) ry_val = alu_res;
    if (ry_in == '0) ry_val = '0;
  end

  assign in_ready = 1'b1;
`else
  function automatic logic dep(input logic v, input logic [RA_W-1:0] rd,
                               input logic [1:0] u, input logic [RA_W-1:0] rx,
                               input logic [RA_W-1:0] ry);
    dep = v && (rd != '0) && ((u[1] && rd == rx) || (u[0] && rd == ry));
  endfunction

  assign rx_val   = regs[rx_in];
  assign ry_val   = regs[ry_in];
  // S3 counts too: its write lands on the same edge this read would be captured.
  assign in_ready = !(dep(s1_valid, s1_rd, use_in, rx_in, ry_in) ||
                      dep(s2_valid, s2_rd, use_in, rx_in, ry_in) ||
                      dep(s3_valid, s3_rd, use_in, rx_in, ry_in));
`endif

  assign opa = use_in[1] ? rx_val : '0;
  assign opb = use_in[0] ? ry_val : imm;

  pipe_alu_unit #(.DATA_W(DATA_W)) u_alu (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_op    <= OP_MV;
      s1_rd    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_rd    <= '0;
      s2_res   <= '0;
      s2_c     <= 1'b0;
      s2_z     <= 1'b0;
      s2_fl    <= '0;
      s3_rd    <= '0;
      s3_res   <= '0;
      s3_c     <= 1'b0;
      s3_z     <= 1'b0;
      s3_fl    <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= op_in;
        s1_rd <= rx_in;
        s1_a  <= opa;
        s1_b  <= opb;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rd  <= s1_rd;
        s2_res <= alu_res;
        s2_c   <= alu_c;
        s2_z   <= alu_z;
        s2_fl  <= flag_upd(s1_op);
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_rd  <= s2_rd;
        s3_res <= s2_res;
        s3_c   <= s2_c;
        s3_z   <= s2_z;
        s3_fl  <= s2_fl;
      end
      wb_valid <= s3_valid;
      if (s3_valid) begin
        wb_addr <= s3_rd;
        wb_data <= s3_res;
        if (s3_rd != '0) regs[s3_rd] <= s3_res;
        if (s3_fl[1]) carry <= s3_c;
        if (s3_fl[0]) zero  <= s3_z;
      end
    end
  end

endmodule
